// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point divider.
// Word format: [23] sign, [22:16] biased exponent, [15:0] fraction with a hidden leading 1.
// There are no zero, infinity or NaN encodings; every bit pattern is an ordinary number.
package fp_pkg;

  localparam int unsigned SIGN     = 1;
  localparam int unsigned EXP      = 7;
  localparam int unsigned FRAC     = 16;
  localparam int unsigned WORD     = SIGN + EXP + FRAC;

  localparam int unsigned SIGN_POS = WORD - 1;
  localparam int unsigned EXP_MSB  = WORD - 2;
  localparam int unsigned EXP_LSB  = FRAC;
  localparam int unsigned FRAC_MSB = FRAC - 1;
  localparam int unsigned FRAC_LSB = 0;

  localparam int          FP_BIAS  = 63;

  // Mantissa including the hidden bit, and the signed exponent-difference width.
  localparam int unsigned MANT     = FRAC + 1;
  localparam int unsigned EDIFF_W  = 10;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StNorm,
    StDone
  } fp_state_e;

endpackage

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider: one quotient bit per clock, MSB first.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       load operands and begin (ignored unless the FSM sends it from idle)
//   a_mant      dividend mantissa {1, frac}
//   b_mant      divisor mantissa {1, frac}
//   done        one-cycle pulse after the last quotient bit is written
//   quo         quotient floor(a_mant * 2^(DIV_STEPS-1) / b_mant)
module fp_mant_divider #(
  parameter int unsigned DIV_STEPS = 18,
  parameter int unsigned MANT      = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MANT-1:0]      a_mant,
  input  logic [MANT-1:0]      b_mant,
  output logic                 done,
  output logic [DIV_STEPS-1:0] quo
);

  // One extra bit so the left-shifted partial remainder (always < 2*divisor) fits.
  localparam int unsigned REM_W = MANT + 1;
  localparam int unsigned CNT_W = $clog2(DIV_STEPS);

  logic [REM_W-1:0]     rem_q;
  logic [MANT-1:0]      div_q;
  logic [DIV_STEPS-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 ge;
  logic [REM_W-1:0]     diff;
  logic [REM_W-1:0]     rem_sel;

  always_comb begin
    ge           = rem_q >= {1'b0, div_q};
    diff         = rem_q - {1'b0, div_q};
    rem_sel      = ge ? diff : rem_q;
    quo_d        = quo_q;
    quo_d[cnt_q] = ge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= {1'b0, a_mant};
        div_q  <= b_mant;
        quo_q  <= '0;
        cnt_q  <= CNT_W'(DIV_STEPS - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= {rem_sel[REM_W-2:0], 1'b0};
        quo_q <= quo_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign quo  = quo_q;

endmodule

// File: rtl/fp_divider.sv
// Floating-point divider with valid/ready handshakes on both sides.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      operand handshake; in_ready is high only when idle
//   in_a, in_b             dividend and divisor
//   out_valid/out_ready    result handshake; result is held until taken
//   out_q                  quotient (truncated, not rounded)
//   out_underflow          final exponent below 0 (exponent field wraps)
//   out_overflow           final exponent above 127 (exponent field wraps)
// Latency: accept at edge k, out_valid after edge k+20.
module fp_divider
  import fp_pkg::*;
#(
  parameter int BIAS      = FP_BIAS,
  parameter int DIV_STEPS = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_a,
  input  logic [WORD-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_q,
  output logic            out_underflow,
  output logic            out_overflow
);

  fp_state_e state_q, state_d;

  logic                      sign_q;
  logic signed [EDIFF_W-1:0] ediff_q;
  logic        [EDIFF_W-1:0] ediff_in;
  logic        [WORD-1:0]    out_q_q;
  logic                      uf_q, of_q;

  logic                      start;
  logic                      div_done;
  logic [DIV_STEPS-1:0]      quo;

  logic signed [EDIFF_W-1:0] norm_e;
  logic [FRAC-1:0]           norm_mant;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign start     = in_valid && in_ready;

  assign ediff_in = {3'b000, in_a[EXP_MSB:EXP_LSB]} - {3'b000, in_b[EXP_MSB:EXP_LSB]}
                  + EDIFF_W'(BIAS);

  fp_mant_divider #(
    .DIV_STEPS (DIV_STEPS),
    .MANT      (MANT)
  ) u_mant_divider (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_mant ({1'b1, in_a[FRAC_MSB:FRAC_LSB]}),
    .b_mant ({1'b1, in_b[FRAC_MSB:FRAC_LSB]}),
    .done   (div_done),
    .quo    (quo)
  );

  // Quotient lies in (2^16, 2^18): its top bit selects a one-place normalising shift.
  always_comb begin
    if (quo[DIV_STEPS-1]) begin
      norm_mant = quo[DIV_STEPS-2 -: FRAC];
      norm_e    = ediff_q;
    end else begin
      norm_mant = quo[DIV_STEPS-3 -: FRAC];
      norm_e    = ediff_q - 10'sd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)     state_d = StDiv;
      StDiv:  if (div_done)  state_d = StNorm;
      StNorm:                state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      ediff_q <= '0;
      out_q_q <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        sign_q  <= in_a[SIGN_POS] ^ in_b[SIGN_POS];
        ediff_q <= $signed(ediff_in);
      end
      if (state_q == StNorm) begin
        out_q_q <= {sign_q, norm_e[EXP-1:0], norm_mant};
        uf_q    <= norm_e < 10'sd0;
        of_q    <= norm_e > 10'sd127;
      end
    end
  end

  assign out_q         = out_q_q;
  assign out_underflow = uf_q;
  assign out_overflow  = of_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vector table, random operands against a
// plain-arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_q;
  logic        out_underflow, out_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_divider dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_q         (out_q),
    .out_underflow (out_underflow),
    .out_overflow  (out_overflow)
  );

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] q;
    logic        uf;
    logic        of;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: real-valued division of the mantissas, truncated, then normalised.
  task automatic model(input logic [23:0] a, input logic [23:0] b,
                       output logic [23:0] q, output logic uf, output logic of);
    int     e;
    longint am, bm, qq, mant;
    e  = int'(a[22:16]) - int'(b[22:16]) + 63;
    am = 65536 + longint'(a[15:0]);
    bm = 65536 + longint'(b[15:0]);
    qq = (am * 131072) / bm;
    if (qq >= 131072) begin
      mant = (qq / 2) % 65536;
    end else begin
      mant = qq % 65536;
      e    = e - 1;
    end
    uf = (e < 0);
    of = (e > 127);
    q  = {a[23] ^ b[23], 7'(e & 127), 16'(mant)};
  endtask

  // Accept one operand pair, check latency, result and the return to idle.
  task automatic run_op(input string name, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] eq, input logic euf, input logic eof);
    int lat;
    @(negedge clk);
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 24'($urandom);
    in_b     = 24'($urandom);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (lat > 60) begin
        check({name, ".timeout"}, 32'd0, 32'd1);
        return;
      end
    end
    check({name, ".latency"}, 32'(lat), 32'd20);
    check({name, ".q"}, 32'(out_q), 32'(eq));
    check({name, ".flags"}, {30'd0, out_underflow, out_overflow}, {30'd0, euf, eof});
    @(posedge clk);
    @(negedge clk);
    check({name, ".idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    logic [23:0] a, b, eq, held;
    logic        euf, eof;
    int          lat;

    vecs[0] = '{a: 24'h3F0000, b: 24'h3F0000, q: 24'h3F0000, uf: 1'b0, of: 1'b0};
    vecs[1] = '{a: 24'h3F0000, b: 24'h3F8000, q: 24'h3E5555, uf: 1'b0, of: 1'b0};
    vecs[2] = '{a: 24'hC08000, b: 24'h3F0000, q: 24'hC08000, uf: 1'b0, of: 1'b0};
    vecs[3] = '{a: 24'hC08000, b: 24'hBF0000, q: 24'h408000, uf: 1'b0, of: 1'b0};
    // E=189 wraps to 61; E=-64 wraps to 64.
    vecs[4] = '{a: 24'h7F0000, b: 24'h00FFFF, q: 24'h3D0000, uf: 1'b0, of: 1'b1};
    vecs[5] = '{a: 24'h000000, b: 24'h7F0000, q: 24'h400000, uf: 1'b1, of: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("reset.q", 32'(out_q), 32'd0);
    check("reset.flags", {30'd0, out_underflow, out_overflow}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].uf, vecs[i].of);
    end

    for (int i = 0; i < 25; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      model(a, b, eq, euf, eof);
      run_op($sformatf("rnd%0d", i), a, b, eq, euf, eof);
    end

    // Backpressure: result held for 10 cycles while junk operands are offered.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 24'h3F0000;
    in_b     = 24'h3F8000;
    @(posedge clk);
    #1;
    lat = 0;
    while (!out_valid && lat < 60) begin
      in_a = 24'($urandom);
      in_b = 24'($urandom);
      @(negedge clk);
      lat++;
    end
    check("bp.reached_done", 32'(out_valid), 32'd1);
    held = 24'h3E5555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_a = 24'($urandom);
      in_b = 24'($urandom);
      check($sformatf("bp.hold%0d", i), {6'd0, out_valid, in_ready, out_q}, {6'd0, 2'b10, held});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.released", {30'd0, in_ready, out_valid}, 32'd2);
    run_op("bp.next", 24'hC08000, 24'hBF0000, 24'h408000, 1'b0, 1'b0);

    // Reset during the ninth division cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 24'h7F0000;
    in_b     = 24'h00FFFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_div.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("rst_div.q_flags", {6'd0, out_underflow, out_overflow, out_q}, 32'd0);
    repeat (15) @(negedge clk);
    check("rst_div.quiet", {30'd0, in_ready, out_valid}, 32'd2);
    run_op("rst_div.after", 24'h3F0000, 24'h3F0000, 24'h3F0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
